// File: rtl/mdu_seq_if.sv
// rtl/mdu_seq_if.sv - request/response handshake and shared-adder bundle for mdu_seq
interface mdu_seq_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] add_a;
    logic [XLEN-1:0] add_b;
    logic            add_cin;
    logic [XLEN-1:0] add_result;
    logic            add_cout;

    modport master (
        output in_valid, op, src1, src2, out_ready, add_result, add_cout,
        input  in_ready, out_valid, result, add_a, add_b, add_cin
    );

    modport slave (
        input  in_valid, op, src1, src2, out_ready, add_result, add_cout,
        output in_ready, out_valid, result, add_a, add_b, add_cin
    );
endinterface

// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - radix-2 multiply/divide sequencer driving a shared external adder
// Define MDU_SIGNED_EN to enable signed MULH/DIV/REM (PRE/POST sign-fixup states).
module mdu_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input logic      clk,
    input logic      rst,
    mdu_seq_if.slave bus
);
    typedef enum logic [2:0] {IDLE, PRE, BUSY, POST, DONE} state_t;

    state_t           state;
    logic [2:0]       op_q;
    logic [XLEN-1:0]  a_q;
    logic [XLEN-1:0]  b_q;
    logic [XLEN-1:0]  hi;
    logic [XLEN-1:0]  lo;
    logic [CNT_W-1:0] cnt;
    logic             res_valid;
    logic [XLEN-1:0]  res_q;
    logic [1:0]       kind_q;
`ifdef MDU_SIGNED_EN
    logic             phase;
    logic             carry;
    logic             neg_lo;
    logic             neg_hi;
    logic [XLEN-1:0]  pre_x;
`endif

    // kind[1]: divide family, kind[0]: result comes from the high register (P or R)
    function automatic logic [1:0] op_kind(input logic [2:0] o);
        case (o)
            3'b001, 3'b100: op_kind = 2'd1;
            3'b010, 3'b101: op_kind = 2'd2;
            3'b011, 3'b110: op_kind = 2'd3;
            default:        op_kind = 2'd0;
        endcase
    endfunction

`ifdef MDU_SIGNED_EN
    function automatic logic is_signed_op(input logic [2:0] o);
        is_signed_op = (o == 3'b100) || (o == 3'b101) || (o == 3'b110);
    endfunction
`endif

    assign kind_q        = op_kind(op_q);
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = res_valid;
    assign bus.result    = res_q;

    always_comb begin
        bus.add_a   = '0;
        bus.add_b   = '0;
        bus.add_cin = 1'b0;
`ifdef MDU_SIGNED_EN
        pre_x       = phase ? b_q : a_q;
`endif
        case (state)
            BUSY: begin
                if (!kind_q[1]) begin
                    bus.add_a = hi;
                    bus.add_b = lo[0] ? a_q : '0;
                end else begin
                    bus.add_a   = {hi[XLEN-2:0], lo[XLEN-1]};
                    bus.add_b   = ~b_q;
                    bus.add_cin = 1'b1;
                end
            end
`ifdef MDU_SIGNED_EN
            PRE: begin
                bus.add_a   = pre_x[XLEN-1] ? ~pre_x : pre_x;
                bus.add_cin = pre_x[XLEN-1];
            end
            POST: begin
                // Multiply negation propagates the low-word carry into the high word
                if (!phase) begin
                    bus.add_a   = neg_lo ? ~lo : lo;
                    bus.add_cin = neg_lo;
                end else begin
                    bus.add_a   = neg_hi ? ~hi : hi;
                    bus.add_cin = neg_hi && (kind_q[1] || carry);
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            hi        <= '0;
            lo        <= '0;
            cnt       <= '0;
            res_valid <= 1'b0;
            res_q     <= '0;
`ifdef MDU_SIGNED_EN
            phase     <= 1'b0;
            carry     <= 1'b0;
            neg_lo    <= 1'b0;
            neg_hi    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_q  <= bus.op;
                        a_q   <= bus.src1;
                        b_q   <= bus.src2;
                        hi    <= '0;
                        lo    <= op_kind(bus.op)[1] ? bus.src1 : bus.src2;
                        cnt   <= '0;
                        state <= BUSY;
`ifdef MDU_SIGNED_EN
                        phase <= 1'b0;
                        carry <= 1'b0;
                        if (!op_kind(bus.op)[1]) begin
                            neg_lo <= bus.src1[XLEN-1] ^ bus.src2[XLEN-1];
                            neg_hi <= bus.src1[XLEN-1] ^ bus.src2[XLEN-1];
                        end else begin
                            neg_lo <= (bus.src1[XLEN-1] ^ bus.src2[XLEN-1]) && (bus.src2 != '0);
                            neg_hi <= bus.src1[XLEN-1];
                        end
                        if (is_signed_op(bus.op)) state <= PRE;
`endif
                    end
                end
`ifdef MDU_SIGNED_EN
                PRE: begin
                    phase <= ~phase;
                    if (!phase) begin
                        a_q <= bus.add_result;
                    end else begin
                        b_q   <= bus.add_result;
                        lo    <= kind_q[1] ? a_q : bus.add_result;
                        state <= BUSY;
                    end
                end
`endif
                BUSY: begin
                    if (!kind_q[1]) begin
                        hi <= {bus.add_cout, bus.add_result[XLEN-1:1]};
                        lo <= {bus.add_result[0], lo[XLEN-1:1]};
                    end else if (hi[XLEN-1] || bus.add_cout) begin
                        hi <= bus.add_result;
                        lo <= {lo[XLEN-2:0], 1'b1};
                    end else begin
                        hi <= {hi[XLEN-2:0], lo[XLEN-1]};
                        lo <= {lo[XLEN-2:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(XLEN-1)) begin
                        state <= DONE;
`ifdef MDU_SIGNED_EN
                        if (is_signed_op(op_q)) state <= POST;
`endif
                    end
                end
`ifdef MDU_SIGNED_EN
                POST: begin
                    phase <= ~phase;
                    if (!phase) begin
                        lo    <= bus.add_result;
                        carry <= bus.add_cout;
                    end else begin
                        hi    <= bus.add_result;
                        state <= DONE;
                    end
                end
`endif
                DONE: begin
                    // First DONE cycle registers the selected word; it then holds until taken
                    if (!res_valid) begin
                        res_valid <= 1'b1;
                        res_q     <= kind_q[0] ? hi : lo;
                    end else if (bus.out_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
